i2c_bus_scheduler: RTL and testbench



---
 rtl/i2c_bus_scheduler.sv | 161 ++++++++++++++++
 tb/tb_i2c_bus_scheduler.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_bus_scheduler.sv
// i2c_bus_scheduler
//   Shares one I2C master between NUM_REQ requesters. A round-robin arbiter
//   picks a winner and latches its address/rw/data. The block then raises
//   dataReady and follows the master's state output until the master is idle
//   again. It reports done, or err on timeout, to the granted requester.
//
// Ports
//   clk, rst_n         system clock, async active-low reset
//   req                per-requester request level
//   req_addr           7-bit slave address per requester (packed, 7 bits each)
//   req_rw             read/write bit per requester
//   req_data           data byte per requester (packed, 8 bits each)
//   grant/done/err     one-hot grant, completion pulse, timeout pulse
//   busy               scheduler not idle
//   m_address, m_rw, m_data, m_data_ready   drive the I2C master
//   m_state            master current-state output
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | wait for a request while the master reports idle
// S_LATCH     | winner's address/rw/data held, grant raised, timer cleared
// S_LAUNCH    | dataReady high until the master leaves idle
// S_WAIT_DONE | master busy; wait for it to return to idle
// S_DONE      | done pulse, advance round-robin pointer
// S_ERR       | err pulse after timeout, advance round-robin pointer
module i2c_bus_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int IDLE_CODE = 1,
  parameter int TIMEOUT   = 1023
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [7*NUM_REQ-1:0]   req_addr,
  input  logic [NUM_REQ-1:0]     req_rw,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     grant,
  output logic [NUM_REQ-1:0]     done,
  output logic [NUM_REQ-1:0]     err,
  output logic                   busy,
  output logic [6:0]             m_address,
  output logic                   m_rw,
  output logic [7:0]             m_data,
  output logic                   m_data_ready,
  input  logic [5:0]             m_state
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [5:0]    IDLE_ST = 6'(IDLE_CODE);
  localparam logic [TW-1:0] T_MAX   = TW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_LAUNCH, S_WAIT_DONE, S_DONE, S_ERR
  } state_t;

  state_t            state, state_next;
  logic [IW-1:0]     g, rr_ptr, win_idx, cand;
  logic              win_found, m_idle;
  logic [TW-1:0]     timer;
  logic [NUM_REQ-1:0] g_onehot;

  assign m_idle   = (m_state == IDLE_ST);
  assign g_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << g;

  // Scan from the highest offset down so the last hit is the nearest set bit
  // at or above rr_ptr (modulo NUM_REQ).
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = IW'((int'(rr_ptr) + i) % NUM_REQ);
      if (req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:      if (win_found && m_idle) state_next = S_LATCH;
      S_LATCH:     state_next = S_LAUNCH;
      S_LAUNCH: begin
        if (!m_idle)             state_next = S_WAIT_DONE;
        else if (timer == T_MAX) state_next = S_ERR;
      end
      S_WAIT_DONE: begin
        if (m_idle)              state_next = S_DONE;
        else if (timer == T_MAX) state_next = S_ERR;
      end
      S_DONE, S_ERR: state_next = S_IDLE;
      default:       state_next = S_IDLE;
    endcase
  end

  always_comb begin
    grant        = '0;
    done         = '0;
    err          = '0;
    m_data_ready = 1'b0;
    busy         = (state != S_IDLE);
    case (state)
      S_LATCH, S_WAIT_DONE: grant = g_onehot;
      S_LAUNCH: begin
        grant        = g_onehot;
        m_data_ready = 1'b1;
      end
      S_DONE: begin
        grant = g_onehot;
        done  = g_onehot;
      end
      S_ERR: begin
        grant = g_onehot;
        err   = g_onehot;
      end
      default: ;
    endcase
  end

  // Winner and its request fields are captured on the edge entering LATCH and
  // then held; later requester input changes are not seen by the master.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g         <= '0;
      rr_ptr    <= '0;
      timer     <= '0;
      m_address <= '0;
      m_rw      <= 1'b0;
      m_data    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          timer <= '0;
          if (state_next == S_LATCH) begin
            g         <= win_idx;
            m_address <= req_addr[int'(win_idx)*7 +: 7];
            m_rw      <= req_rw[win_idx];
            m_data    <= req_data[int'(win_idx)*8 +: 8];
          end
        end
        S_LATCH: timer <= '0;
        S_LAUNCH: begin
          if (state_next == S_WAIT_DONE) timer <= '0;
          else if (timer != T_MAX)       timer <= timer + 1'b1;
        end
        S_WAIT_DONE: if (timer != T_MAX) timer <= timer + 1'b1;
        S_DONE, S_ERR: rr_ptr <= (g == IW'(NUM_REQ - 1)) ? '0 : g + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_bus_scheduler.sv
module tb_i2c_bus_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req, req_t;
  logic [27:0] req_addr;
  logic [3:0]  req_rw;
  logic [31:0] req_data;
  logic [3:0]  grant, done, err;
  logic        busy, m_rw, m_data_ready;
  logic [6:0]  m_address;
  logic [7:0]  m_data;
  logic [5:0]  m_state = 6'd1;

  logic [3:0]  grant_t, done_t, err_t;
  logic        busy_t, m_rw_t, m_data_ready_t;
  logic [6:0]  m_address_t;
  logic [7:0]  m_data_t;
  logic [5:0]  m_state_t;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int         idx;
    logic [6:0] addr;
    logic       rw;
    logic [7:0] data;
    bit         is_err;
  } exp_t;
  exp_t sb[$];

  bit force_busy = 1'b0;
  int busy_len   = 40;
  int cnt        = 0;

  always #5 clk = ~clk;

  i2c_bus_scheduler #(.NUM_REQ(4), .IDLE_CODE(1), .TIMEOUT(1023)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .req_rw(req_rw),
    .req_data(req_data), .grant(grant), .done(done), .err(err), .busy(busy),
    .m_address(m_address), .m_rw(m_rw), .m_data(m_data),
    .m_data_ready(m_data_ready), .m_state(m_state)
  );

  i2c_bus_scheduler #(.NUM_REQ(4), .IDLE_CODE(1), .TIMEOUT(15)) dut_t (
    .clk(clk), .rst_n(rst_n), .req(req_t), .req_addr(req_addr), .req_rw(req_rw),
    .req_data(req_data), .grant(grant_t), .done(done_t), .err(err_t), .busy(busy_t),
    .m_address(m_address_t), .m_rw(m_rw_t), .m_data(m_data_t),
    .m_data_ready(m_data_ready_t), .m_state(m_state_t)
  );

  // Master model: leaves idle on the edge after it sees dataReady, stays busy
  // busy_len cycles, then returns to idle. force_busy models a stray transfer.
  always @(posedge clk) begin
    if (force_busy) m_state <= 6'd5;
    else if (m_state != 6'd1) begin
      if (cnt == 0) m_state <= 6'd1;
      else          cnt <= cnt - 1;
    end else if (m_data_ready) begin
      m_state <= 6'd2;
      cnt     <= busy_len - 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_slot(input int i, input logic [6:0] a, input logic rw, input logic [7:0] d);
    req_addr[i*7 +: 7] = a;
    req_rw[i]          = rw;
    req_data[i*8 +: 8] = d;
  endtask

  task automatic push_exp(input int i, input bit is_err);
    exp_t e;
    e.idx    = i;
    e.addr   = req_addr[i*7 +: 7];
    e.rw     = req_rw[i];
    e.data   = req_data[i*8 +: 8];
    e.is_err = is_err;
    sb.push_back(e);
  endtask

  // Waits for a done/err pulse, checks it against the scoreboard head, then
  // checks the following idle sample.
  task automatic wait_end(input int budget);
    exp_t       e;
    logic [3:0] pg, exp_vec;
    logic [7:0] pd;
    bit         unstable, seen;
    unstable = 1'b0;
    seen     = 1'b0;
    pg       = grant;
    pd       = m_data;
    for (int k = 0; k < budget && !seen; k++) begin
      if (|done || |err) seen = 1'b1;
      else begin
        @(negedge clk);
        if (grant != 4'b0 && grant == pg && m_data != pd) unstable = 1'b1;
        pg = grant;
        pd = m_data;
      end
    end
    chk("end_pulse_seen", 32'(seen), 32'd1);
    if (!seen) return;
    chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
    if (sb.size() == 0) return;
    e       = sb.pop_front();
    exp_vec = 4'b0001 << e.idx;
    chk("done_vec", done, e.is_err ? 4'b0 : exp_vec);
    chk("err_vec", err, e.is_err ? exp_vec : 4'b0);
    chk("grant_at_end", grant, exp_vec);
    chk("m_address", m_address, e.addr);
    chk("m_data", m_data, e.data);
    chk("m_rw", m_rw, e.rw);
    chk("m_data_stable", 32'(unstable), 32'd0);
    @(negedge clk);
    chk("idle_after_pulse", {grant, done, err, busy}, 13'd0);
  endtask

  initial begin
    int n, c;
    bit bad;
    rst_n = 1'b0; req = '0; req_t = '0; req_addr = '0; req_rw = '0; req_data = '0;
    m_state_t = 6'd1;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {grant, done, err, busy, m_data_ready, m_rw, m_address, m_data}, 30'd0);
    chk("reset_outputs_t", {grant_t, done_t, err_t, busy_t, m_data_ready_t}, 14'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single request
    set_slot(0, 7'h3C, 1'b0, 8'hA5);
    push_exp(0, 1'b0);
    req = 4'b0001;
    n = 0;
    while (!m_data_ready && n < 20) begin @(negedge clk); n++; end
    chk("t1_ready_seen", 32'(m_data_ready), 32'd1);
    chk("t1_latch", {grant, m_rw, m_address, m_data}, {4'b0001, 1'b0, 7'h3C, 8'hA5});
    c = 0;
    while (m_data_ready && c < 20) begin c++; @(negedge clk); end
    chk("t1_ready_cycles", c, 2);
    chk("t1_mstate_at_drop", m_state, 6'd2);
    n = 0;
    while (m_state != 6'd1 && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    chk("t1_done_latency", done, 4'b0001);
    wait_end(4);
    req = '0;

    // Contention from reset
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) set_slot(i, 7'(8'h10 + i), 1'(i), 8'(8'h40 + i));
    push_exp(0, 1'b0); push_exp(1, 1'b0); push_exp(2, 1'b0); push_exp(3, 1'b0); push_exp(0, 1'b0);
    req = 4'b1111;
    repeat (5) wait_end(200);
    req = '0;

    // Round-robin wrap: serve 3, then 1001 must pick 0
    push_exp(3, 1'b0);
    req = 4'b1000;
    wait_end(200);
    push_exp(0, 1'b0);
    push_exp(3, 1'b0);
    req = 4'b1001;
    wait_end(200);
    wait_end(200);
    req = '0;

    // Input change after grant
    set_slot(1, 7'h50, 1'b1, 8'h11);
    push_exp(1, 1'b0);
    req = 4'b0010;
    n = 0;
    while (!m_data_ready && n < 20) begin @(negedge clk); n++; end
    while (m_data_ready && n < 40) begin @(negedge clk); n++; end
    req_data[15:8] = 8'h22;
    wait_end(100);
    req = '0;

    // Requester drops req while granted
    set_slot(2, 7'h2A, 1'b1, 8'h5A);
    push_exp(2, 1'b0);
    req = 4'b0100;
    n = 0;
    while (grant != 4'b0100 && n < 20) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    req = '0;
    wait_end(100);

    // Stray master activity while idle
    force_busy = 1'b1;
    repeat (2) @(negedge clk);
    set_slot(3, 7'h61, 1'b0, 8'hC3);
    req = 4'b1000;
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (grant != 4'b0 || busy) bad = 1'b1;
    end
    chk("t6_no_grant_stray", 32'(bad), 32'd0);
    push_exp(3, 1'b0);
    force_busy = 1'b0;
    wait_end(100);
    req = '0;

    // Reset mid-transfer
    set_slot(0, 7'h33, 1'b0, 8'h77);
    req = 4'b0001;
    n = 0;
    while (!m_data_ready && n < 20) begin @(negedge clk); n++; end
    while (m_data_ready && n < 40) begin @(negedge clk); n++; end
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t7_async_reset", {grant, done, err, busy, m_data_ready, m_address, m_data}, 28'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    n = 0;
    while (m_state != 6'd1 && n < 100) begin
      if (grant != 4'b0 || busy) bad = 1'b1;
      @(negedge clk);
      n++;
    end
    chk("t7_no_grant_while_master_busy", 32'(bad), 32'd0);
    chk("t7_master_idle_seen", m_state, 6'd1);
    chk("t7_still_idle_at_master_idle", {grant, busy}, 5'd0);
    push_exp(0, 1'b0);
    wait_end(100);
    req = '0;

    // Launch timeout on the TIMEOUT=15 instance, master held idle
    req_t = 4'b0100;
    n = 0;
    while (!m_data_ready_t && n < 20) begin @(negedge clk); n++; end
    chk("t8_latched", {m_rw_t, m_address_t, m_data_t}, {1'b1, 7'h2A, 8'h5A});
    c = 0;
    while (m_data_ready_t && c < 100) begin c++; @(negedge clk); end
    chk("t8_launch_ready_cycles", c, 16);
    chk("t8_err_pulse", {done_t, err_t, grant_t, m_data_ready_t}, {4'b0000, 4'b0100, 4'b0100, 1'b0});
    req_t = '0;
    @(negedge clk);
    chk("t8_back_to_idle", {busy_t, grant_t, err_t, done_t}, 13'd0);

    // Wait-done timeout: master leaves idle and never returns
    req_t = 4'b0001;
    n = 0;
    while (!m_data_ready_t && n < 20) begin @(negedge clk); n++; end
    m_state_t = 6'd2;
    @(negedge clk);
    chk("t9_ready_dropped", {m_data_ready_t, grant_t}, {1'b0, 4'b0001});
    c = 0;
    while (err_t == 4'b0 && c < 100) begin @(negedge clk); c++; end
    chk("t9_wait_cycles", c, 16);
    chk("t9_err_pulse", {done_t, err_t}, {4'b0000, 4'b0001});
    req_t = '0;
    m_state_t = 6'd1;
    @(negedge clk);
    chk("t9_back_to_idle", {busy_t, grant_t, err_t, done_t}, 13'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
